timer_ctrl: RTL

Programmable interval-timer controller for the free-running counter datapath. It owns a counter instance and sequences it through start, stop, resume and clear commands over a valid/ready command port. The block generates a one-cycle `tick` at each programmed terminal count, in one-shot or periodic mode. It sits between a host or CSR front-end and any logic that needs timed events, such as watchdogs, sample strobes or timeouts.

---
 rtl/timer_ctrl_pkg.sv | 14 +
 rtl/counter_core.sv | 23 ++
 rtl/timer_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared FSM state type and command opcodes for timer_ctrl.
//   timer_state_t : IDLE / RUN / DONE
//   OP_*          : cmd_op encodings (START, STOP, RESUME, CLEAR)
package timer_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;
  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;
endpackage

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit up counter with enable and synchronous clear.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear, has priority over i_en
//   i_en    : increment enable
//   o_q     : current count
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= r_q + WIDTH'(1'b1);
  end
  assign o_q = r_q;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer sequencing a counter_core via a
// valid/ready command port (START/STOP/RESUME/CLEAR), one-shot or periodic.
//   clk, reset_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready low for one cycle after reset)
//   cmd_op              : 00 START, 01 STOP, 10 RESUME, 11 CLEAR
//   cmd_period          : terminal count, latched on START
//   cmd_periodic        : 1 periodic / 0 one-shot, latched on START
//   cmd_prescale        : divisor minus one (only with TIMER_CTRL_PRESCALE_EN)
//   count_q             : current count
//   tick                : one-cycle pulse at terminal count
//   busy                : high while running
//   done                : set when a one-shot expires, cleared by START/CLEAR
// Optional feature macro: TIMER_CTRL_PRESCALE_EN adds the clock prescaler.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_period,
  input  logic               cmd_periodic,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [PRESC_W-1:0] cmd_prescale,
`endif
  output logic [WIDTH-1:0]   count_q,
  output logic               tick,
  output logic               busy,
  output logic               done
);
  timer_state_t     r_state;
  logic             r_ready;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             r_periodic;
  logic [WIDTH-1:0] r_period;
  logic             w_acc;
  logic             w_start;
  logic             w_clear;
  logic             w_adv;
  logic             w_term;
  logic             w_run_adv;
  assign w_acc   = cmd_valid && r_ready;
  assign w_start = w_acc && cmd_op == OP_START;
  assign w_clear = w_acc && cmd_op == OP_CLEAR;
`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_div;
  assign w_adv = r_presc == r_presc_div;
  // Prescaler only moves while running undisturbed; any accepted command freezes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_presc_div <= '0;
    end else begin
      if (w_start) r_presc_div <= cmd_prescale;
      if (w_start || w_clear) r_presc <= '0;
      else if (!w_acc && r_state == RUN) r_presc <= w_adv ? '0 : r_presc + PRESC_W'(1'b1);
    end
  end
`else
  assign w_adv = 1'b1;
`endif
  // An accepted command in the same cycle overrides counting, so no tick/done then.
  assign w_run_adv = !w_acc && r_state == RUN && w_adv;
  assign w_term    = w_run_adv && count_q == r_period;
  counter_core #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start || w_clear || w_term),
    .i_en    (w_run_adv),
    .o_q     (count_q)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_period   <= '0;
      r_periodic <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_tick  <= w_term;
      if (w_start) begin
        r_period   <= cmd_period;
        r_periodic <= cmd_periodic;
        r_state    <= RUN;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end else if (w_clear) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_acc && cmd_op == OP_STOP && r_state == RUN) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (w_acc && cmd_op == OP_RESUME && r_state == IDLE) begin
        r_state <= RUN;
        r_busy  <= 1'b1;
      end else if (w_term && !r_periodic) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end
  assign cmd_ready = r_ready;
  assign tick      = r_tick;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
